// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one synchronous data-RAM port between the multi-cycle CPU and a
// debug/loader requester. Every access walks IDLE -> ACCESS -> WAIT -> DONE.
// Simultaneous requests are resolved round-robin.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   cpu_*             CPU request side; cpu_ready pulses for one cycle in DONE
//   dbg_*             debug request side; dbg_ack pulses for one cycle in DONE
//   ram_*             RAM port; ram_dout is valid the cycle after the address
//   gnt               current owner: 00 none, 01 CPU, 10 debug
//   busy              high whenever an access is in progress
module ram_port_arbiter #(
    parameter int         ADDR_W   = 10,
    parameter logic [2:0] DBG_CTRL = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_ramctrl,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [2:0]        ram_ctrl,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    output logic [1:0]        gnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Owner encoding: 0 = CPU, 1 = debug
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_grant_reg, last_grant_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [2:0]        ctrl_reg, ctrl_next;
    logic [31:0]       rdata_reg [2];

    logic grant_cpu;
    logic grant_dbg;

    // Upper CPU address bits are deliberately ignored (word address only).
    logic unused_cpu_addr_hi;
    assign unused_cpu_addr_hi = ^cpu_addr[31:ADDR_W];

    // CPU wins when alone, or on a tie when debug had the previous grant.
    assign grant_cpu = cpu_req && (!dbg_req || (last_grant_reg == OWN_DBG));
    assign grant_dbg = dbg_req && !grant_cpu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_CPU;
            last_grant_reg <= OWN_DBG;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            ctrl_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            ctrl_reg       <= ctrl_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        ctrl_next       = ctrl_reg;
        case (state_reg)
            IDLE: begin
                if (grant_cpu) begin
                    state_next      = ACCESS;
                    owner_next      = OWN_CPU;
                    last_grant_next = OWN_CPU;
                    we_next         = cpu_we;
                    addr_next       = cpu_addr[ADDR_W-1:0];
                    wdata_next      = cpu_wdata;
                    ctrl_next       = cpu_ramctrl;
                end else if (grant_dbg) begin
                    state_next      = ACCESS;
                    owner_next      = OWN_DBG;
                    last_grant_next = OWN_DBG;
                    we_next         = dbg_we;
                    addr_next       = dbg_addr;
                    wdata_next      = dbg_wdata;
                    ctrl_next       = DBG_CTRL;
                end
            end
            ACCESS:  state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data lands in the owner's register at the WAIT->DONE edge; the
    // other requester's register is untouched, and writes never update it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_reg[gi] <= '0;
                end else if (state_reg == WAIT && !we_reg && owner_reg == 1'(gi)) begin
                    rdata_reg[gi] <= ram_dout;
                end
            end
        end
    endgenerate

    assign cpu_rdata = rdata_reg[0];
    assign dbg_rdata = rdata_reg[1];

    // Decoded straight from the state register so the async reset drops
    // ram_we and the handshakes without waiting for a clock.
    assign ram_we    = (state_reg == ACCESS) && we_reg;
    assign ram_addr  = addr_reg;
    assign ram_din   = wdata_reg;
    assign ram_ctrl  = ctrl_reg;
    assign cpu_ready = (state_reg == DONE) && (owner_reg == OWN_CPU);
    assign dbg_ack   = (state_reg == DONE) && (owner_reg == OWN_DBG);
    assign busy      = (state_reg != IDLE);
    assign gnt       = (state_reg == IDLE) ? 2'b00 :
                       ((owner_reg == OWN_DBG) ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: table-driven single accesses plus
// hand-written sequences for reset, contention and reset mid-access.
module tb_ram_port_arbiter;

    localparam int         ADDR_W   = 10;
    localparam logic [2:0] DBG_CTRL = 3'b000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]       cpu_addr = '0, cpu_wdata = '0;
    logic [2:0]        cpu_ramctrl = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_wdata = '0;
    logic [31:0]       dbg_rdata;
    logic              dbg_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [2:0]        ram_ctrl;
    logic              ram_we;
    logic [31:0]       ram_dout;
    logic [1:0]        gnt;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_cpu_rdata = '0;
    logic [31:0] exp_dbg_rdata = '0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DBG_CTRL(DBG_CTRL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ramctrl(cpu_ramctrl),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_ctrl(ram_ctrl),
        .ram_we(ram_we), .ram_dout(ram_dout), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: registered read, write on ram_we
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          dbg;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic [9:0]  exp_addr;
        logic [2:0]  exp_ctrl;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(bit dbg, bit we, logic [31:0] addr, logic [31:0] wdata,
                                logic [2:0] ctrl, logic [9:0] exp_addr, logic [2:0] exp_ctrl,
                                logic [31:0] exp_rdata);
        vec_t v;
        v.dbg = dbg; v.we = we; v.addr = addr; v.wdata = wdata; v.ctrl = ctrl;
        v.exp_addr = exp_addr; v.exp_ctrl = exp_ctrl; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Called #1 after a posedge with the DUT idle; returns #1 after the
    // posedge that brings it back to IDLE.
    task automatic do_access(input vec_t v);
        if (v.dbg) begin
            dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr[9:0]; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
            cpu_wdata = v.wdata; cpu_ramctrl = v.ctrl;
        end
        @(posedge clk); #1;
        // Requester fields are don't-care after the grant edge
        if (v.dbg) begin
            dbg_addr = 10'($urandom); dbg_wdata = $urandom; dbg_we = ~v.we;
        end else begin
            cpu_addr = $urandom; cpu_wdata = $urandom; cpu_ramctrl = 3'($urandom); cpu_we = ~v.we;
        end
        check("access_gnt", 32'(gnt), v.dbg ? 32'd2 : 32'd1);
        check("access_we", 32'(ram_we), 32'(v.we));
        check("access_addr", 32'(ram_addr), 32'(v.exp_addr));
        check("access_ctrl", 32'(ram_ctrl), 32'(v.exp_ctrl));
        if (v.we) check("access_din", ram_din, v.wdata);
        check("access_handshake", {30'd0, cpu_ready, dbg_ack}, 32'd0);
        @(posedge clk); #1;
        check("wait_we", 32'(ram_we), 32'd0);
        check("wait_addr", 32'(ram_addr), 32'(v.exp_addr));
        check("wait_handshake", {30'd0, cpu_ready, dbg_ack}, 32'd0);
        @(posedge clk); #1;
        check("done_handshake", {30'd0, cpu_ready, dbg_ack}, v.dbg ? 32'd1 : 32'd2);
        check("done_busy", 32'(busy), 32'd1);
        cpu_req = 1'b0; dbg_req = 1'b0;
        if (!v.we) begin
            if (v.dbg) exp_dbg_rdata = v.exp_rdata;
            else       exp_cpu_rdata = v.exp_rdata;
        end
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_gnt", 32'(gnt), 32'd0);
        check("idle_handshake", {30'd0, cpu_ready, dbg_ack}, 32'd0);
        check("cpu_rdata", cpu_rdata, exp_cpu_rdata);
        check("dbg_rdata", dbg_rdata, exp_dbg_rdata);
        $display("txn %s %s addr=%h wdata=%h cpu_rdata=%h dbg_rdata=%h",
                 v.dbg ? "DBG" : "CPU", v.we ? "WR" : "RD", v.exp_addr, v.wdata,
                 cpu_rdata, dbg_rdata);
    endtask

    vec_t vecs[9];
    int   ev_cycle[4];
    bit   ev_dbg[4];
    int   n_ev;

    initial begin
        vecs[0] = mk(1, 1, 32'h0000_0005, 32'hDEAD_BEEF, 3'b111, 10'h005, DBG_CTRL, 32'h0);
        vecs[1] = mk(0, 0, 32'h0000_0014 >> 2, 32'h0, 3'b010, 10'h005, 3'b010, 32'hDEAD_BEEF);
        vecs[2] = mk(1, 1, 32'h0000_03FF, 32'h1234_5678, 3'b000, 10'h3FF, DBG_CTRL, 32'h0);
        vecs[3] = mk(0, 0, 32'h0000_03FF, 32'h0, 3'b001, 10'h3FF, 3'b001, 32'h1234_5678);
        vecs[4] = mk(0, 1, 32'h0000_0404, 32'hCAFE_F00D, 3'b010, 10'h004, 3'b010, 32'h0);
        vecs[5] = mk(1, 0, 32'h0000_0004, 32'h0, 3'b000, 10'h004, DBG_CTRL, 32'hCAFE_F00D);
        vecs[6] = mk(0, 0, 32'hFFFF_FC05, 32'h0, 3'b100, 10'h005, 3'b100, 32'hDEAD_BEEF);
        vecs[7] = mk(1, 0, 32'h0000_0005, 32'h0, 3'b000, 10'h005, DBG_CTRL, 32'hDEAD_BEEF);
        vecs[8] = mk(0, 0, 32'h0000_0015, 32'h0, 3'b011, 10'h015, 3'b011, 32'h2222_2222);

        // Reset held with random inputs: every output must read zero
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom;
            cpu_wdata = $urandom; cpu_ramctrl = 3'($urandom);
            dbg_req = 1'($urandom); dbg_we = 1'($urandom);
            dbg_addr = 10'($urandom); dbg_wdata = $urandom;
            @(posedge clk); #1;
            check("rst_outputs", {cpu_ready, dbg_ack, ram_we, busy, gnt, 26'd0}, 32'd0);
            check("rst_ram_addr", 32'(ram_addr), 32'd0);
            check("rst_rdata", cpu_rdata | dbg_rdata | ram_din, 32'd0);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_no_req", {30'd0, busy, ram_we}, 32'd0);
        end

        // Contention: both held for four accesses, CPU must win the first tie
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h14; cpu_wdata = 32'h1111_1111; cpu_ramctrl = 3'b010;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h15; dbg_wdata = 32'h2222_2222;
        n_ev = 0;
        for (int c = 1; c <= 24 && n_ev < 4; c++) begin
            @(posedge clk); #1;
            check("no_overlap", 32'(cpu_ready & dbg_ack), 32'd0);
            if (cpu_ready || dbg_ack) begin
                ev_cycle[n_ev] = c;
                ev_dbg[n_ev]   = dbg_ack;
                n_ev++;
                if (n_ev == 4) begin
                    cpu_req = 1'b0; dbg_req = 1'b0;
                end
            end
        end
        check("contention_count", 32'(n_ev), 32'd4);
        for (int i = 0; i < n_ev; i++) begin
            check("contention_owner", 32'(ev_dbg[i]), 32'(i % 2));
            check("contention_cycle", 32'(ev_cycle[i]), 32'(3 + 4 * i));
            $display("txn contention %0d %s done at cycle %0d", i, ev_dbg[i] ? "DBG" : "CPU", ev_cycle[i]);
        end
        @(posedge clk); #1;
        check("contention_idle", 32'(busy), 32'd0);
        check("contention_rdata", cpu_rdata | dbg_rdata, 32'd0);

        // Table of single accesses
        foreach (vecs[i]) do_access(vecs[i]);

        // Reset during ACCESS of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h5; cpu_wdata = 32'hAAAA_5555; cpu_ramctrl = 3'b010;
        @(posedge clk); #1;
        check("mid_rst_access_we", 32'(ram_we), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_we_async", 32'(ram_we), 32'd0);
        check("mid_rst_busy", {29'd0, busy, gnt}, 32'd0);
        check("mid_rst_ready", 32'(cpu_ready), 32'd0);
        check("mid_rst_rdata", cpu_rdata | dbg_rdata, 32'd0);
        exp_cpu_rdata = '0; exp_dbg_rdata = '0;
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_ready", {30'd0, cpu_ready, dbg_ack}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        do_access(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single data-RAM port (10-bit address, 32-bit data, 3-bit RAMCtrl, we) between the multi-cycle CPU and a debug/loader port.
- The debug/loader port is used for program load and memory inspection.
- Sits between MultiCPU, the debug requester and RAM.
- Drives the CPU's MIO_ready handshake, so CPU memory states stall until the arbiter completes the access.

Parameters:
ADDR_W, 10, RAM word-address width; cpu_addr[ADDR_W-1:0] is forwarded
DBG_CTRL, 3'b000, RAMCtrl code driven for debug-port accesses (full-word access)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low
cpu_req  input  1  CPU access request; held until cpu_ready
cpu_we  input  1  CPU write (1) / read (0)
cpu_addr  input  32  CPU address; only [ADDR_W-1:0] used
cpu_wdata  input  32  CPU write data
cpu_ramctrl  input  3  CPU RAMCtrl code, passed through unchanged
cpu_rdata  output  32  CPU read data, registered
cpu_ready  output  1  one-cycle completion pulse (to MIO_ready)
dbg_req  input  1  debug access request; held until dbg_ack
dbg_we  input  1  debug write / read
dbg_addr  input  ADDR_W  debug address
dbg_wdata  input  32  debug write data
dbg_rdata  output  32  debug read data, registered
dbg_ack  output  1  one-cycle completion pulse
ram_addr  output  ADDR_W  RAM address
ram_din  output  32  RAM write data
ram_ctrl  output  3  RAM RAMCtrl
ram_we  output  1  RAM write enable
ram_dout  input  32  RAM read data; synchronous RAM, valid the cycle after address is presented
gnt  output  2  current owner: 00 none, 01 CPU, 10 debug
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = DBG, so the CPU wins the first tie.
- Reset is asynchronous: asserting rst mid-access forces ram_we=0, ready/ack=0 and state IDLE immediately.
  - The in-flight access is abandoned with no completion pulse.
  - A write cut by reset is not guaranteed to be committed.
- FSM: IDLE -> ACCESS -> WAIT -> DONE -> IDLE. Every access takes exactly 4 states.
- IDLE:
  - Neither req: stay.
  - One req: grant it.
  - Both req: grant the requester not equal to last_grant (round-robin).
  - On grant, latch we/addr/wdata/ctrl into internal registers and update last_grant.
  - Requester fields are don't-care after the grant edge.
- ACCESS:
  - ram_addr/ram_din/ram_ctrl driven from the latched fields.
  - ram_we = latched we, for this cycle only.
  - gnt shows the owner.
- WAIT:
  - ram_addr/ram_ctrl held; ram_we=0; ram_dout valid.
  - On a read, ram_dout is captured into the owner's rdata register at the end of WAIT.
- DONE:
  - Owner's ready/ack = 1 for exactly this cycle.
  - rdata is valid and held until that requester's next read completes.
  - Writes never modify rdata.
  - The other requester's rdata is never disturbed.
- After DONE, always return to IDLE. A requester must drop req in the cycle after ready/ack; a req still high in IDLE is a new request.
- Latency and throughput:
  - Request sampled at edge t gives ACCESS at t+1, WAIT at t+2, DONE at t+3.
  - Throughput is one access per 4 cycles.
- A losing requester keeps waiting; round-robin bounds its wait to one access (≤4 cycles extra).
- Outside ACCESS/WAIT: ram_we=0; ram_addr/ram_din/ram_ctrl hold their last values (no glitching required); gnt=00 in IDLE.
- cpu_addr bits above ADDR_W-1 are ignored; there is no fault.
- Debug accesses always use ram_ctrl = DBG_CTRL.
- ready and ack are never simultaneously 1.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, gnt=00, busy=0; release, no req -> stays idle.
- CPU read: RAM[5]=0xDEADBEEF; cpu_req=1, we=0, addr=0x0000_0014>>2 word 5 -> ram_addr=5 in ACCESS, cpu_ready pulses exactly 3 cycles after the request edge, cpu_rdata=0xDEADBEEF and held afterwards.
- Debug write then CPU read: dbg write 0x12345678 to addr 0x3FF with ram_we high exactly one cycle -> dbg_ack pulse; CPU then reads 0x3FF -> 0x12345678; dbg_rdata unchanged.
- Contention: cpu_req and dbg_req both held continuously for 4 accesses -> grant order CPU, DBG, CPU, DBG; each completion 4 cycles apart; ready/ack never overlap.
- Address truncation: CPU write to 0x0000_0404 -> ram_addr=0x004; ram_ctrl equals cpu_ramctrl (e.g. 3'b010); debug access drives DBG_CTRL.
- Reset mid-access: assert rst during ACCESS of a CPU write -> ram_we falls without waiting for a clock, no cpu_ready; after release, a fresh CPU read completes normally in 3 cycles.
